// File: rtl/boolean_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the bench or host driving it.
// The master drives the request and the observed DUT output; the slave returns the sweep status.
interface boolean_sweep_checker_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned TRUTH_W = 1 << N_IN;

  logic               start;
  logic [TRUTH_W-1:0] truth;
  logic               dut_y;
  logic [N_IN-1:0]    vec;
  logic               busy;
  logic               done;
  logic               pass;
  logic [N_IN:0]      err_cnt;
  logic [N_IN-1:0]    first_fail;

  modport master (
    output start, truth, dut_y,
    input  vec, busy, done, pass, err_cnt, first_fail
  );

  modport slave (
    input  start, truth, dut_y,
    output vec, busy, done, pass, err_cnt, first_fail
  );
endinterface

// File: rtl/boolean_sweep_checker.sv
// Exhaustively sweeps a small combinational DUT through every input vector and
// counts outputs that disagree with a supplied truth table.
module boolean_sweep_checker #(
  parameter int unsigned N_IN = 3,
  parameter int unsigned HOLD = 2
) (
  input logic                  clk,
  input logic                  rst,
  boolean_sweep_checker_if.slave bus
);
  localparam int unsigned CNT_W  = N_IN + 1;
  localparam int unsigned HOLD_W = 8;
  localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [N_IN-1:0]     ff_q, ff_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                last_hold_c;
  logic                mismatch_c;

  assign last_hold_c = (hold_q == HOLD_LAST);
  assign mismatch_c  = (bus.dut_y != bus.truth[vec_q]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_hold_c && (vec_q == VEC_LAST)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs
  always_comb begin
    vec_d  = vec_q;
    hold_d = hold_q;
    err_d  = err_q;
    ff_d   = ff_q;
    pass_d = pass_q;
    done_d = 1'b0;
    busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d  = '0;
          hold_d = '0;
          err_d  = '0;
          ff_d   = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (last_hold_c) begin
          hold_d = '0;
          if (mismatch_c) begin
            err_d = err_q + CNT_W'(1);
            if (err_q == '0) ff_d = vec_q;
          end
          // Final vector: leave RUN rather than wrapping the sweep
          if (vec_q == VEC_LAST) begin
            vec_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_q == '0) && !mismatch_c;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_FIN: begin
        vec_d = '0;
      end
      default: begin
        vec_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      hold_q <= '0;
      err_q  <= '0;
      ff_q   <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      hold_q <= hold_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      pass_q <= pass_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = ff_q;
endmodule

// File: doc/boolean_sweep_checker.md
BOOLEAN_SWEEP_CHECKER -- requirements
Module: boolean_sweep_checker

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the number of DUT input bits; legal range 1..8.
REQ-002 The block SHALL have parameter HOLD, default 2, giving the clock cycles each vector is applied; legal range 1..255.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port START, input, 1, a request to begin a sweep, sampled on CLK.
REQ-006 The block SHALL have port TRUTH, input, 2**N_IN, the expected DUT output; bit i is expected for vector value i.
REQ-007 The block SHALL have port DUT_Y, input, 1, the observed output of the combinational DUT.
REQ-008 The block SHALL have port VEC, output, N_IN, the input vector driven to the DUT; VEC[N_IN-1] is MSB (A), VEC[0] is LSB.
REQ-009 The block SHALL have port BUSY, output, 1, high while a sweep is running.
REQ-010 The block SHALL have port DONE, output, 1, a one-cycle pulse at sweep completion.
REQ-011 The block SHALL have port PASS, output, 1, high when the last completed sweep had zero mismatches.
REQ-012 The block SHALL have port ERR_CNT, output, N_IN+1, the mismatch count of the current or last sweep.
REQ-013 The block SHALL have port FIRST_FAIL, output, N_IN, the vector index of the first mismatch; meaningful only when ERR_CNT is nonzero.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-015 In IDLE, START=1 SHALL move the FSM to RUN on the next edge and clear VEC, the hold counter, ERR_CNT, FIRST_FAIL and PASS.
REQ-016 BUSY SHALL be 1 exactly in RUN; VEC SHALL be 0 outside RUN.
REQ-017 In RUN, each VEC value SHALL be held for exactly HOLD cycles, with values running 0,1,...,2**N_IN-1 in order.
REQ-018 The DUT_Y vs TRUTH[VEC] compare SHALL occur only in the last hold cycle of each vector; HOLD=1 compares in the same cycle the vector is applied.
REQ-019 On a mismatch, ERR_CNT SHALL increment by 1; the count cannot overflow, since its maximum is 2**N_IN.
REQ-020 On the first mismatch of a sweep, FIRST_FAIL SHALL capture VEC; later mismatches SHALL NOT change it.
REQ-021 After the compare of vector 2**N_IN-1, the FSM SHALL enter FIN; VEC SHALL NOT wrap to 0 within RUN.
REQ-022 RUN SHALL last exactly HOLD*2**N_IN cycles.
REQ-023 FIN SHALL last one cycle with DONE=1, then return to IDLE.
REQ-024 PASS SHALL be set in FIN iff the final ERR_CNT, including the last compare, is 0.
REQ-025 PASS, ERR_CNT and FIRST_FAIL SHALL hold their values through IDLE until the next accepted START or RST.
REQ-026 START during RUN or FIN SHALL be ignored, with no restart and no extra DONE.
REQ-027 START in the IDLE cycle right after FIN SHALL be accepted normally.
REQ-028 TRUTH SHALL be sampled live at each compare; the bench holds it stable for the whole sweep.

Reset
REQ-029 RST=1 at a rising edge SHALL force on that edge: IDLE state, VEC=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, hold counter=0.
REQ-030 RST SHALL have priority over START and over any in-progress RUN or FIN.
REQ-031 A sweep aborted by RST SHALL produce no DONE.

Verification (N_IN=3, HOLD=2 unless stated)
REQ-032 Power-up reset: RST=1 for 2 cycles -> all outputs 0, and BUSY stays 0 with START=0.
REQ-033 AND3 sweep: TRUTH=8'b1000_0000, DUT_Y=&VEC, one-cycle START -> VEC steps 0..7, each held 2 cycles; DONE 16 cycles after BUSY rises; PASS=1, ERR_CNT=0.
REQ-034 XOR3 expected with DUT_Y tied 0: TRUTH=8'b1001_0110 -> ERR_CNT=4, FIRST_FAIL=1, PASS=0 at DONE; values hold 10 idle cycles.
REQ-035 START held high for the entire sweep -> exactly one DONE for the first sweep; a second sweep starts the cycle after FIN, with ERR_CNT cleared.
REQ-036 RST pulsed while VEC=5 in RUN -> next cycle VEC=0, BUSY=0, ERR_CNT=0, no DONE; a subsequent START yields a full 16-cycle sweep.
REQ-037 N_IN=1, HOLD=1, TRUTH=2'b01 with DUT_Y=~VEC[0] -> RUN lasts 2 cycles, ERR_CNT=0, PASS=1.
